// File: rtl/rr_x_in_lock.sv
// Registered round-robin / fixed-priority arbiter with multi-flit grant locking
// and an optional lock timeout that forces release after LOCK_MAX cycles in LOCK.
module rr_x_in_lock #(
  parameter int IO_SIZE  = 5,
  parameter int IO_w     = 3,
  parameter int LOCK_MAX = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IO_SIZE-1:0] req_i,
  input  logic [IO_SIZE-1:0] hold_i,
  input  logic               ack_i,
  input  logic               mode_i,
  output logic [IO_SIZE-1:0] grant_o,
  output logic               grant_valid_o,
  output logic [IO_w-1:0]    grant_id_o,
  output logic [IO_w-1:0]    ptr_o,
  output logic               lock_abort_o
);

  localparam int CW = (LOCK_MAX > 0) ? $clog2(LOCK_MAX + 1) : 1;
  localparam logic [CW-1:0]   CNT_LIM = CW'((LOCK_MAX > 0) ? LOCK_MAX - 1 : 0);
  localparam logic [IO_w-1:0] LAST    = IO_w'(IO_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_LOCK} state_t;

  state_t             r_state, w_nstate;
  logic [IO_SIZE-1:0] r_grant, w_ngrant;
  logic [IO_w-1:0]    r_id, w_nid;
  logic [IO_w-1:0]    r_ptr, w_nptr;
  logic [CW-1:0]      r_cnt, w_ncnt;
  logic               r_abort, w_nabort;
  logic               w_rel, w_adv, w_arb;
  logic [IO_w-1:0]    w_start;
  logic [IO_w:0]      w_pick;

  // Returns {found, index} of the first set request scanning circularly from start.
  function automatic logic [IO_w:0] pick(input logic [IO_SIZE-1:0] req,
                                         input logic [IO_w-1:0] start);
    logic          found;
    logic [IO_w-1:0] sel;
    logic [IO_w:0] t;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < IO_SIZE; k++) begin
      t = {1'b0, start} + (IO_w+1)'(k);
      if (t >= (IO_w+1)'(IO_SIZE)) t = t - (IO_w+1)'(IO_SIZE);
      if (!found && req[t[IO_w-1:0]]) begin
        found = 1'b1;
        sel   = t[IO_w-1:0];
      end
    end
    return {found, sel};
  endfunction

  always_comb begin
    w_nstate = r_state;
    w_ngrant = r_grant;
    w_nid    = r_id;
    w_nptr   = r_ptr;
    w_ncnt   = r_cnt;
    w_nabort = 1'b0;
    w_rel    = 1'b0;
    w_adv    = 1'b0;
    w_arb    = 1'b0;
    case (r_state)
      S_IDLE: w_arb = 1'b1;
      S_GRANT: begin
        if (ack_i && hold_i[r_id]) begin
          w_nstate = S_LOCK;
          w_ncnt   = '0;
        end else if (ack_i) begin
          w_rel = 1'b1;
          w_adv = 1'b1;
        end else if (!req_i[r_id]) begin
          w_rel = 1'b1;
        end
      end
      S_LOCK: begin
        // A normal acked release wins over a coincident timeout, so no abort pulse then.
        if (ack_i && !hold_i[r_id]) begin
          w_rel = 1'b1;
          w_adv = 1'b1;
        end else if (LOCK_MAX > 0 && r_cnt == CNT_LIM) begin
          w_rel    = 1'b1;
          w_adv    = 1'b1;
          w_nabort = 1'b1;
        end else begin
          w_ncnt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_nstate = S_IDLE;
        w_ngrant = '0;
        w_nid    = '0;
      end
    endcase

    if (w_rel) begin
      w_arb = 1'b1;
      if (w_adv && !mode_i) w_nptr = (r_id == LAST) ? '0 : r_id + IO_w'(1);
    end

    w_start = mode_i ? '0 : w_nptr;
    w_pick  = pick(req_i, w_start);

    if (w_arb) begin
      if (w_pick[IO_w]) begin
        w_nstate = S_GRANT;
        w_ngrant = IO_SIZE'(1) << w_pick[IO_w-1:0];
        w_nid    = w_pick[IO_w-1:0];
      end else begin
        w_nstate = S_IDLE;
        w_ngrant = '0;
        w_nid    = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_id    <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_grant <= w_ngrant;
      r_id    <= w_nid;
      r_ptr   <= w_nptr;
      r_cnt   <= w_ncnt;
      r_abort <= w_nabort;
    end
  end

  assign grant_o       = r_grant;
  assign grant_valid_o = |r_grant;
  assign grant_id_o    = r_id;
  assign ptr_o         = r_ptr;
  assign lock_abort_o  = r_abort;

endmodule
